// File: rtl/fetch_reorder_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_reorder_queue
//  Description : Collapsing fetch-side instruction queue. Emits one entry per
//                cycle in program order, dropping non-delay-slot nops,
//                hoisting an independent lw over up to WINDOW-1 older entries
//                and filling an empty branch delay slot with the preceding
//                independent instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_reorder_queue #(
   parameter int DEPTH    = 4,
   parameter int WINDOW   = 2,
   parameter bit SKIP_NOP = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_pc,
   input  logic [31:0]              in_instr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_instr,
   output logic                     out_hoisted,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   typedef enum logic [0:0] {NORMAL = 1'b0, DSLOT = 1'b1} state_t;

   // {is_branch_or_jump, is_lw}
   function automatic logic [1:0] instruction_traits(input logic [31:0] ins);
      logic [5:0] op;
      logic [5:0] fn;
      logic       br;
      op = ins[31:26];
      fn = ins[5:0];
      br = (op >= 6'h01 && op <= 6'h07) || (op == 6'h00 && (fn == 6'h08 || fn == 6'h09));
      return {br, op == 6'h23};
   endfunction

   // {read mask, write mask}; bits 0..31 are GPRs ($0 excluded), bit 32 is memory
   function automatic logic [65:0] rw_mask(input logic [31:0] ins);
      logic [32:0] r;
      logic [32:0] w;
      logic [5:0]  rs;
      logic [5:0]  rt;
      logic [5:0]  rd;
      r  = '0;
      w  = '0;
      rs = {1'b0, ins[25:21]};
      rt = {1'b0, ins[20:16]};
      rd = {1'b0, ins[15:11]};
      case (ins[31:26])
         6'h00: begin
            r[rs] = 1'b1;
            r[rt] = 1'b1;
            if (ins[5:0] != 6'h08) w[rd] = 1'b1;
         end
         6'h01, 6'h06, 6'h07: r[rs] = 1'b1;
         6'h02: ;
         6'h03: w[31] = 1'b1;
         6'h04, 6'h05: begin
            r[rs] = 1'b1;
            r[rt] = 1'b1;
         end
         6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
            r[rs] = 1'b1;
            w[rt] = 1'b1;
         end
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
            r[rs] = 1'b1;
            r[32] = 1'b1;
            w[rt] = 1'b1;
         end
         6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e: begin
            r[rs] = 1'b1;
            r[rt] = 1'b1;
            w[32] = 1'b1;
         end
         default: begin
            r[rs] = 1'b1;
            r[rt] = 1'b1;
         end
      endcase
      r[0] = 1'b0;
      w[0] = 1'b0;
      return {r, w};
   endfunction

   function automatic logic indep(input logic [32:0] ra, input logic [32:0] wa,
                                  input logic [32:0] rb, input logic [32:0] wb);
      return ((wa & (rb | wb)) == '0) && ((wb & (ra | wa)) == '0);
   endfunction

   logic [31:0]      q_pc    [DEPTH];
   logic [31:0]      q_instr [DEPTH];
   logic [32:0]      q_rm    [DEPTH];
   logic [32:0]      q_wm    [DEPTH];
   logic [DEPTH-1:0] q_kill;
   logic [DEPTH-1:0] q_br;
   logic [DEPTH-1:0] q_lw;
   logic [CW-1:0]    cnt;
   state_t           state;
   logic             ready_q;

   logic             lock;
   logic [IW-1:0]    lock_idx;
   logic             lock_hoist;
   logic             lock_fill;
   state_t           lock_state;

   logic             emit;
   logic             drop;
   logic [IW-1:0]    sel;
   logic             sel_hoist;
   logic             sel_fill;
   state_t           sel_state;
   logic             found;
   logic             blocked;
   logic             ok;

   logic             fire;
   logic             remove;
   logic             push;
   logic [IW-1:0]    rem;
   logic [CW-1:0]    cnt_after;
   logic [CW-1:0]    cnt_next;
   logic [IW-1:0]    wr_idx;

   // Choose the entry to present: the frozen choice while locked, else first matching rule
   always_comb begin
      emit      = 1'b0;
      drop      = 1'b0;
      sel       = '0;
      sel_hoist = 1'b0;
      sel_fill  = 1'b0;
      sel_state = state;
      found     = 1'b0;
      blocked   = 1'b0;
      ok        = 1'b0;
      if (lock) begin
         emit      = 1'b1;
         sel       = lock_idx;
         sel_hoist = lock_hoist;
         sel_fill  = lock_fill;
         sel_state = lock_state;
      end else if (cnt != '0) begin
         if (q_kill[0]) begin
            drop = 1'b1;
         end else if (state == DSLOT) begin
            emit      = 1'b1;
            sel_state = q_br[0] ? DSLOT : NORMAL;
         end else if (SKIP_NOP && q_instr[0] == 32'd0) begin
            drop = 1'b1;
         end else if (q_br[0]) begin
            emit      = 1'b1;
            sel_state = DSLOT;
         end else if (cnt >= CW'(3) && q_br[1] && q_instr[2] == 32'd0 && !q_lw[0] &&
                      !q_kill[1] && !q_kill[2] &&
                      indep(q_rm[0], q_wm[0], q_rm[1], q_wm[1])) begin
            // entry0 becomes the delay slot; the original nop slot is killed
            emit      = 1'b1;
            sel       = IW'(1);
            sel_hoist = 1'b1;
            sel_fill  = 1'b1;
            sel_state = DSLOT;
         end else begin
            emit    = 1'b1;
            blocked = q_lw[0];
            for (int k = 1; k < WINDOW; k++) begin
               if (!found && !blocked && CW'(k) < cnt && q_lw[k] && !q_kill[k]) begin
                  ok = 1'b1;
                  for (int j = 0; j < k; j++) begin
                     ok = ok & indep(q_rm[j], q_wm[j], q_rm[k], q_wm[k]);
                  end
                  if (ok) begin
                     found     = 1'b1;
                     sel       = IW'(k);
                     sel_hoist = 1'b1;
                  end
               end
               blocked = blocked | q_lw[k] | q_br[k] | q_kill[k];
            end
         end
      end
   end

   assign fire        = emit & out_ready;
   assign remove      = fire | drop;
   assign rem         = drop ? '0 : sel;
   assign push        = in_valid & in_ready;
   assign cnt_after   = cnt - CW'(remove);
   assign cnt_next    = cnt_after + CW'(push);
   assign wr_idx      = cnt_after[IW-1:0];

   assign out_valid   = emit;
   assign out_pc      = emit ? q_pc[sel] : 32'd0;
   assign out_instr   = emit ? q_instr[sel] : 32'd0;
   assign out_hoisted = emit & sel_hoist;
   assign count       = cnt;
   assign in_ready    = ready_q & ~reset;

   // Queue storage, compaction, enqueue, slot state and backpressure lock
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         cnt        <= '0;
         state      <= NORMAL;
         ready_q    <= 1'b1;
         lock       <= 1'b0;
         lock_idx   <= '0;
         lock_hoist <= 1'b0;
         lock_fill  <= 1'b0;
         lock_state <= NORMAL;
      end else begin
         if (remove) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               if (i >= int'(rem)) begin
                  q_pc[i]    <= q_pc[i+1];
                  q_instr[i] <= q_instr[i+1];
                  q_rm[i]    <= q_rm[i+1];
                  q_wm[i]    <= q_wm[i+1];
                  q_kill[i]  <= q_kill[i+1];
                  q_br[i]    <= q_br[i+1];
                  q_lw[i]    <= q_lw[i+1];
               end
            end
         end
         // after compaction the nop that followed the hoisted branch sits at rem
         if (fire && sel_fill) q_kill[rem] <= 1'b1;
         if (push) begin
            q_pc[wr_idx]                  <= in_pc;
            q_instr[wr_idx]               <= in_instr;
            q_kill[wr_idx]                <= 1'b0;
            {q_br[wr_idx], q_lw[wr_idx]}  <= instruction_traits(in_instr);
            {q_rm[wr_idx], q_wm[wr_idx]}  <= rw_mask(in_instr);
         end
         cnt     <= cnt_next;
         ready_q <= (cnt_next < CW'(DEPTH));
         if (fire) begin
            state <= sel_state;
            lock  <= 1'b0;
         end else if (emit && !lock) begin
            lock       <= 1'b1;
            lock_idx   <= sel;
            lock_hoist <= sel_hoist;
            lock_fill  <= sel_fill;
            lock_state <= sel_state;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_fetch_reorder_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_reorder_queue
//  Description : Directed bench with a queue-level reference model for
//                fetch_reorder_queue plus literal per-scenario expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_reorder_queue;
   localparam int DEPTH  = 4;
   localparam int WINDOW = 2;

   localparam logic [31:0] ADDU = 32'h014B4821;
   localparam logic [31:0] LW_I = 32'h8C880000;
   localparam logic [31:0] LW_D = 32'h8D280000;
   localparam logic [31:0] BEQ  = 32'h11000004;
   localparam logic [31:0] NOP  = 32'h00000000;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_hoisted;
   logic [31:0] in_pc, in_instr, out_pc, out_instr;
   logic [2:0]  count;

   int n_chk  = 0;
   int n_fail = 0;

   fetch_reorder_queue #(.DEPTH(DEPTH), .WINDOW(WINDOW), .SKIP_NOP(1'b1)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_instr(out_instr), .out_hoisted(out_hoisted), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (instruction semantics, queue of entries)
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        kill;
   } ent_t;

   function automatic bit m_is_br(input logic [31:0] i);
      return (i[31:26] inside {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7}) ||
             (i[31:26] == 6'd0 && (i[5:0] inside {6'h08, 6'h09}));
   endfunction

   function automatic bit m_is_lw(input logic [31:0] i);
      return i[31:26] == 6'h23;
   endfunction

   // register set read / written, bit 32 stands for memory
   function automatic logic [32:0] m_reads(input logic [31:0] i);
      logic [32:0] s = '0;
      int op = int'(i[31:26]);
      int rs = int'(i[25:21]);
      int rt = int'(i[20:16]);
      if (op == 2 || op == 3) s = '0;
      else if (op == 1 || op == 6 || op == 7 || (op >= 8 && op <= 15)) s[rs] = 1'b1;
      else if (op >= 32 && op <= 38) begin s[rs] = 1'b1; s[32] = 1'b1; end
      else begin s[rs] = 1'b1; s[rt] = 1'b1; end
      s[0] = 1'b0;
      return s;
   endfunction

   function automatic logic [32:0] m_writes(input logic [31:0] i);
      logic [32:0] s = '0;
      int op = int'(i[31:26]);
      if (op == 0 && i[5:0] != 6'h08) s[int'(i[15:11])] = 1'b1;
      else if (op == 3) s[31] = 1'b1;
      else if ((op >= 8 && op <= 15) || (op >= 32 && op <= 38)) s[int'(i[20:16])] = 1'b1;
      else if (op inside {40, 41, 42, 43, 46}) s[32] = 1'b1;
      s[0] = 1'b0;
      return s;
   endfunction

   function automatic bit m_indep(input logic [31:0] a, input logic [31:0] b);
      return ((m_writes(a) & (m_reads(b) | m_writes(b))) == 0) &&
             ((m_writes(b) & (m_reads(a) | m_writes(a))) == 0);
   endfunction

   ent_t mq[$];
   ent_t tmp;
   bit   m_dslot, m_ready, m_held, h_hoist, h_fill, h_nds;
   int   h_idx;
   bit   e_emit, e_drop, e_hoist, e_fill, e_nds, ok;
   int   e_idx;

   logic [31:0] log_pc[$];
   logic [31:0] log_ins[$];
   logic        log_h[$];

   task automatic model_select();
      e_emit = 0; e_drop = 0; e_idx = 0; e_hoist = 0; e_fill = 0; e_nds = m_dslot;
      if (m_held) begin
         e_emit = 1; e_idx = h_idx; e_hoist = h_hoist; e_fill = h_fill; e_nds = h_nds;
      end else if (mq.size() > 0) begin
         if (mq[0].kill) e_drop = 1;
         else if (m_dslot) begin e_emit = 1; e_nds = m_is_br(mq[0].instr); end
         else if (mq[0].instr == 0) e_drop = 1;
         else if (m_is_br(mq[0].instr)) begin e_emit = 1; e_nds = 1; end
         else if (mq.size() >= 3 && m_is_br(mq[1].instr) && mq[2].instr == 0 &&
                  !m_is_lw(mq[0].instr) && !mq[1].kill && !mq[2].kill &&
                  m_indep(mq[0].instr, mq[1].instr)) begin
            e_emit = 1; e_idx = 1; e_hoist = 1; e_fill = 1; e_nds = 1;
         end else begin
            e_emit = 1;
            for (int k = 1; k < WINDOW && k < mq.size(); k++) begin
               ok = m_is_lw(mq[k].instr) && !mq[k].kill;
               for (int j = 0; j < k; j++)
                  if (m_is_lw(mq[j].instr) || m_is_br(mq[j].instr) || mq[j].kill ||
                      !m_indep(mq[j].instr, mq[k].instr)) ok = 0;
               if (ok && !e_hoist) begin e_idx = k; e_hoist = 1; end
            end
         end
      end
   endtask

   // Compare every cycle against the model, then advance the model to the next edge
   always @(negedge clk) begin
      if (reset) begin
         chk("in_ready_during_reset", {31'd0, in_ready}, 32'd0);
         mq.delete(); m_dslot = 0; m_held = 0; m_ready = 1;
      end else begin
         model_select();
         chk("out_valid", {31'd0, out_valid}, {31'd0, e_emit});
         chk("count", {29'd0, count}, mq.size());
         chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
         if (e_emit) begin
            chk("out_pc", out_pc, mq[e_idx].pc);
            chk("out_instr", out_instr, mq[e_idx].instr);
            chk("out_hoisted", {31'd0, out_hoisted}, {31'd0, e_hoist});
         end
         if (out_valid && out_ready && !flush) begin
            log_pc.push_back(out_pc); log_ins.push_back(out_instr); log_h.push_back(out_hoisted);
         end
         if (flush) begin
            mq.delete(); m_dslot = 0; m_held = 0; m_ready = 1;
         end else begin
            if (e_emit && out_ready) begin
               if (e_fill) begin tmp = mq[e_idx+1]; tmp.kill = 1; mq[e_idx+1] = tmp; end
               mq.delete(e_idx);
               m_dslot = e_nds;
               m_held  = 0;
            end else if (e_emit) begin
               m_held = 1; h_idx = e_idx; h_hoist = e_hoist; h_fill = e_fill; h_nds = e_nds;
            end else if (e_drop) begin
               mq.delete(0);
            end
            if (in_valid && m_ready) begin
               tmp.pc = in_pc; tmp.instr = in_instr; tmp.kill = 0;
               mq.push_back(tmp);
            end
            m_ready = mq.size() < DEPTH;
         end
      end
   end

   // ---------------- stimulus helpers
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] pc, input logic [31:0] ins);
      int n = 0;
      in_valid = 1; in_pc = pc; in_instr = ins;
      while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
      if (!in_ready) chk("send_timeout_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic do_flush();
      flush = 1; @(posedge clk); #1; flush = 0;
      log_pc.delete(); log_ins.delete(); log_h.delete();
   endtask

   function automatic logic [31:0] lpc(input int i);
      return (i < log_pc.size()) ? log_pc[i] : 32'hDEADBEEF;
   endfunction

   function automatic logic [31:0] lh(input int i);
      return (i < log_h.size()) ? {31'd0, log_h[i]} : 32'hDEADBEEF;
   endfunction

   task automatic chk_log(input string s, input int n, input logic [31:0] p0, input logic [31:0] p1,
                          input logic [31:0] p2, input logic [31:0] p3, input logic [3:0] h);
      logic [31:0] pl [4];
      pl[0] = p0; pl[1] = p1; pl[2] = p2; pl[3] = p3;
      chk({s, "_emitted_count"}, log_pc.size(), n);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_pc%0d", s, i), lpc(i), pl[i]);
         chk($sformatf("%s_hoisted%0d", s, i), lh(i), {31'd0, h[i]});
      end
   endtask

   initial begin
      reset = 1; flush = 0; in_valid = 0; in_pc = 0; in_instr = 0; out_ready = 0;
      idle(3);
      chk("reset_in_ready_low", {31'd0, in_ready}, 32'd0);
      reset = 0; #1;
      chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("post_reset_count", {29'd0, count}, 32'd0);
      chk("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("post_reset_out_pc", out_pc, 32'd0);
      chk("post_reset_out_instr", out_instr, 32'd0);
      chk("post_reset_hoisted", {31'd0, out_hoisted}, 32'd0);
      do_flush();

      // nop skip
      out_ready = 1;
      send(32'h3000, NOP); send(32'h3004, ADDU); idle(4);
      chk_log("nop_skip", 1, 32'h3004, 0, 0, 0, 4'b0000);
      do_flush();

      // lw hoist: a leading entry stalls decode until the pair is queued
      out_ready = 0;
      send(32'h2FFC, ADDU); send(32'h3000, ADDU); send(32'h3004, LW_I);
      out_ready = 1; idle(5);
      chk_log("lw_hoist", 3, 32'h2FFC, 32'h3004, 32'h3000, 0, 4'b0010);
      do_flush();

      // dependent lw stays in order
      out_ready = 0;
      send(32'h2FFC, ADDU); send(32'h3000, ADDU); send(32'h3004, LW_D);
      out_ready = 1; idle(5);
      chk_log("lw_dep", 3, 32'h2FFC, 32'h3000, 32'h3004, 0, 4'b0000);
      do_flush();

      // branch fill (queue runs full, then 0x300C arrives after a removal)
      out_ready = 0;
      send(32'h2FFC, ADDU); send(32'h3000, ADDU); send(32'h3004, BEQ); send(32'h3008, NOP);
      #1 chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1;
      send(32'h300C, ADDU); idle(6);
      chk_log("branch_fill", 4, 32'h2FFC, 32'h3004, 32'h3000, 32'h300C, 4'b0010);
      do_flush();

      // delay-slot nop is emitted
      out_ready = 1;
      send(32'h3000, BEQ); send(32'h3004, NOP); idle(4);
      chk_log("dslot", 2, 32'h3000, 32'h3004, 0, 0, 4'b0000);
      chk("dslot_nop_instr", (log_ins.size() > 1) ? log_ins[1] : 32'hDEADBEEF, NOP);
      do_flush();

      // backpressure stability, then flush overriding a handshake and an enqueue
      out_ready = 0;
      send(32'h3000, ADDU); send(32'h3004, LW_I);
      for (int i = 0; i < 3; i++) begin
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_pc", out_pc, 32'h3000);
         chk("stall_hoisted", {31'd0, out_hoisted}, 32'd0);
         idle(1);
      end
      flush = 1; out_ready = 1; in_valid = 1; in_pc = 32'h4000; in_instr = ADDU;
      idle(1);
      flush = 0; in_valid = 0; #1;
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_count", {29'd0, count}, 32'd0);
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
      chk("flush_no_emit", log_pc.size(), 0);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fetch_reorder_queue.md
Name: fetch_reorder_queue

Overview:
- Parametrised fetch-side instruction queue between instruction fetch and decode.
- Buffers up to DEPTH fetched instructions and emits one per cycle in program order, with three exceptions:
  - discards non-delay-slot nops;
  - hoists an independent lw ahead of up to WINDOW-1 older instructions;
  - fills an empty branch delay slot by hoisting the branch over the preceding independent instruction.
- Replaces the single-entry buffer/select pair with a multi-entry, handshaked, flushable queue.

Parameters:
DEPTH, 4, queue entries (power of two, >= 3)
WINDOW, 2, entries examined for lw hoisting (2 <= WINDOW <= DEPTH)
SKIP_NOP, 1, discard nops that are not delay slots

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
flush  input  1  redirect; discard all queued entries
in_valid  input  1  fetch presents an instruction
in_ready  output  1  queue accepts (registered, count < DEPTH)
in_pc  input  32  fetched pc
in_instr  input  32  fetched instruction word
out_valid  output  1  emitted instruction valid
out_ready  input  1  decode accepts
out_pc  output  32  emitted pc
out_instr  output  32  emitted instruction
out_hoisted  output  1  emitted entry was not the head
count  output  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset values: queue empty, count=0, state NORMAL, lock=0, out_valid=0, out_hoisted=0, out_pc=0, out_instr=0. in_ready=0 while reset is high and 1 in the first cycle after it.
- Storage: collapsing queue; entry 0 is the oldest.
  - Each entry holds pc, instr, kill, and rmask/wmask/type bits.
  - rmask/wmask/type are computed at enqueue with InstructionTraits and RWMask.
- Enqueue: on in_valid && in_ready, append at the tail. Enqueue and removal can happen in the same cycle; the new entry lands after compaction.
- Independence of X and Y: no overlap between wmask(X) and rmask|wmask(Y), and none between wmask(Y) and rmask|wmask(X).
- Selection is evaluated only while lock=0, by the first matching rule:
  - (a) Head kill=1: drop the head silently; out_valid=0.
  - (b) State DSLOT and head valid: emit the head unmodified, including a nop; then state=NORMAL, or stay DSLOT if the head is itself a branch/jump.
  - (c) SKIP_NOP && head instr==0: drop silently; out_valid=0.
  - (d) Head is branch/jump: emit the head; state=DSLOT.
  - (e) Branch fill: all of the following hold:
    - entries 0..2 are valid;
    - entry1 is a branch/jump;
    - entry2 instr==0;
    - entry0 is neither a branch/jump nor an lw;
    - entry0 and entry1 are independent.
    Then emit entry1 with hoisted=1, set entry2.kill=1, and state=DSLOT (entry0 becomes the delay slot).
  - (f) lw hoist: pick the lowest k in 1..WINDOW-1 such that:
    - entries 0..k are valid;
    - entry k is an lw;
    - no entry 0..k-1 is an lw or a branch/jump;
    - entry k is independent of every entry 0..k-1.
    Emit entry k with hoisted=1.
  - (g) Otherwise emit the head.
- Backpressure:
  - out_valid && !out_ready sets lock=1 and latches the chosen index.
  - Outputs stay bit-stable until acceptance, even if enqueue grows the window.
  - Removal, kill marking and state update happen only on out_valid && out_ready; lock clears then.
- flush: next cycle count=0, state NORMAL, lock=0, out_valid=0. in_valid is ignored in the flush cycle. flush overrides a simultaneous handshake.
- Empty queue: out_valid=0. Full queue: in_ready=0, and reopens the cycle after a removal.
- Hoisting never crosses an entry marked kill.
- Reset mid-transfer discards everything, identical to flush.

Test Plan:
- Nop skip: enqueue 0x00000000@0x3000, 0x014B4821@0x3004 -> first out_valid shows pc 0x3004, hoisted=0; pc 0x3000 is never emitted.
- lw hoist: addu 0x014B4821@0x3000, lw 0x8C880000@0x3004 -> emit 0x3004 (hoisted=1), then 0x3000 (hoisted=0).
- Dependence block: addu 0x014B4821@0x3000, lw $t0,0($t1) 0x8D280000@0x3004 -> in-order 0x3000, 0x3004; hoisted stays 0.
- Branch fill: addu@0x3000, beq 0x11000004@0x3004, nop@0x3008, addu@0x300C -> emit 0x3004, 0x3000, 0x300C; 0x3008 is never emitted.
- Delay-slot protection: beq 0x11000004@0x3000, nop@0x3004 -> both emitted in order, with nop 0x00000000 on out_instr.
- Backpressure/flush: out_ready=0 for 3 cycles while an lw arrives -> outputs are stable. Then assert flush -> next cycle out_valid=0, count=0, in_ready=1.
